// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS core: sequences fetch/decode/execute/
// memory/writeback and drives the datapath selects, write enables and memory handshake.
module multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_req,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       ext_sign,
    output logic       illegal_op
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [STATE_W-1:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE,
        ALUWB, BRANCH, ADDIEX, LOGIEX, IMMWB, JUMP
    } state_t;

    state_t state_q, state_d;
    logic   logi_q;
    logic   pcwrite, branch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            logi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            // remembers that IMMWB follows a logical-immediate execute
            logi_q  <= (state_q == LOGIEX);
        end
    end

    always_comb begin
        state_d    = FETCH;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        ext_sign   = 1'b1;
        illegal_op = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pcwrite  = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (op)
                    OP_LW, OP_SW:    state_d = MEMADR;
                    OP_RTYPE:        state_d = EXECUTE;
                    OP_BEQ:          state_d = BRANCH;
                    OP_ADDI:         state_d = ADDIEX;
                    OP_ANDI, OP_ORI: state_d = LOGIEX;
                    OP_J:            state_d = JUMP;
                    default:         illegal_op = 1'b1;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord    = 1'b1;
                mem_req = 1'b1;
                state_d = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_req   = 1'b1;
                mem_write = 1'b1;
                state_d   = mem_ready ? FETCH : MEMWR;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = IMMWB;
            end
            LOGIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
                ext_sign  = 1'b0;
                state_d   = IMMWB;
            end
            IMMWB: begin
                reg_write = 1'b1;
                if (logi_q) begin
                    alu_op   = 2'b11;
                    ext_sign = 1'b0;
                end
            end
            JUMP: begin
                pc_src  = 2'b10;
                pcwrite = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    assign pc_en = pcwrite | (branch & zero);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: each instruction is modelled as a list of
// phases; every cycle the full control word is compared against the phase's expected word.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, iord, mem_req, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, ext_sign, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_req;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       ext_sign;
        logic       illegal_op;
    } ctl_t;

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .iord(iord), .mem_req(mem_req), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_src(pc_src), .ext_sign(ext_sign), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    function automatic ctl_t observed();
        return {pc_en, iord, mem_req, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                alu_src_a, alu_src_b, alu_op, pc_src, ext_sign, illegal_op};
    endfunction

    function automatic bit is_legal(logic [5:0] o);
        return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                         6'b001000, 6'b001100, 6'b001101, 6'b000010};
    endfunction

    // Expected control word for one phase of an instruction.
    function automatic ctl_t ctl_for(string ph, bit rdy, bit z, bit ill);
        ctl_t c = '0;
        c.ext_sign = 1'b1;
        case (ph)
            "F":    begin c.mem_req = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_en = rdy; end
            "D":    begin c.alu_src_b = 2'b11; c.illegal_op = ill; end
            "MA":   begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            "MR":   begin c.iord = 1; c.mem_req = 1; end
            "MWB":  begin c.mem_to_reg = 1; c.reg_write = 1; end
            "MWR":  begin c.iord = 1; c.mem_req = 1; c.mem_write = 1; end
            "EX":   begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            "AWB":  begin c.reg_dst = 1; c.reg_write = 1; end
            "BR":   begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.pc_en = z; end
            "AX":   begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            "LX":   begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = 2'b11; c.ext_sign = 0; end
            "IWBA": begin c.reg_write = 1; end
            "IWBL": begin c.reg_write = 1; c.alu_op = 2'b11; c.ext_sign = 0; end
            "J":    begin c.pc_src = 2'b10; c.pc_en = 1; end
            default: c = 'x;
        endcase
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one instruction phase by phase. rnd: random mem_ready/zero/fetch waits;
    // otherwise fetch is ready at once and the memory phase waits mwaits cycles.
    task automatic run_instr(input logic [5:0] opc, input bit rnd, input bit zv,
                             input int mwaits, input bit abort,
                             output int nmw, output int nrw);
        string seq[$];
        int    idx = 0;
        int    waited = 0;
        bit    rdy, memph;
        string ph;
        nmw = 0;
        nrw = 0;
        seq = '{"F", "D"};
        case (opc)
            6'b100011:            seq = {seq, "MA", "MR", "MWB"};
            6'b101011:            seq = {seq, "MA", "MWR"};
            6'b000000:            seq = {seq, "EX", "AWB"};
            6'b000100:            seq.push_back("BR");
            6'b001000:            seq = {seq, "AX", "IWBA"};
            6'b001100, 6'b001101: seq = {seq, "LX", "IWBL"};
            6'b000010:            seq.push_back("J");
            default: ;
        endcase
        while (idx < seq.size()) begin
            @(negedge clk);
            ph = seq[idx];
            op = (ph == "D" || ph == "MA") ? opc : 6'($urandom);
            memph = (ph == "F" || ph == "MR" || ph == "MWR");
            if (rnd) begin
                rdy  = ($urandom_range(0, 2) != 0) || (waited >= 3);
                zero = 1'($urandom);
            end else begin
                rdy  = !((ph == "MR" || ph == "MWR") && waited < mwaits);
                zero = zv;
            end
            mem_ready = rdy;
            #1;
            chk($sformatf("op%b_%s_c%0d", opc, ph, waited), 32'(observed()),
                32'(ctl_for(ph, rdy, zero, !is_legal(opc))));
            if (mem_write) nmw++;
            if (reg_write) nrw++;
            if (abort && ph == "MWR") begin
                reset = 1'b1;
                repeat (2) @(posedge clk);
                @(negedge clk);
                mem_ready = 1'b1;
                #1;
                chk("rst_hold_fetch", 32'(observed()), 32'(ctl_for("F", 1'b1, zero, 1'b0)));
                chk("rst_hold_no_wr", 32'({mem_write, reg_write}), 32'd0);
                reset     = 1'b0;
                mem_ready = 1'b0;
                #1;
                chk("post_reset_fetch", 32'(observed()), 32'(ctl_for("F", 1'b0, zero, 1'b0)));
                return;
            end
            if (memph && !rdy) waited++;
            else begin
                idx++;
                waited = 0;
            end
        end
    endtask

    initial begin
        int nmw, nrw;
        logic [5:0] rop;
        logic [5:0] ops [8];
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                6'b001000, 6'b001100, 6'b001101, 6'b000010};
        reset = 1'b1; mem_ready = 1'b0; op = '0; zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_state", 32'(observed()), 32'(ctl_for("F", 1'b0, 1'b0, 1'b0)));
        reset = 1'b0;

        run_instr(6'b100011, 0, 0, 0, 0, nmw, nrw);
        chk("lw_reg_write_cycles", 32'(nrw), 32'd1);
        run_instr(6'b101011, 0, 0, 3, 0, nmw, nrw);
        chk("sw_mem_write_cycles", 32'(nmw), 32'd4);
        chk("sw_no_reg_write", 32'(nrw), 32'd0);
        run_instr(6'b000100, 0, 1, 0, 0, nmw, nrw);
        run_instr(6'b000100, 0, 0, 0, 0, nmw, nrw);
        run_instr(6'b001100, 0, 0, 0, 0, nmw, nrw);
        run_instr(6'b001000, 0, 0, 0, 0, nmw, nrw);
        run_instr(6'b001101, 0, 0, 0, 0, nmw, nrw);
        run_instr(6'b111111, 0, 0, 0, 0, nmw, nrw);
        chk("illegal_no_writes", 32'(nmw + nrw), 32'd0);
        run_instr(6'b000000, 0, 0, 0, 0, nmw, nrw);
        run_instr(6'b000010, 0, 0, 0, 0, nmw, nrw);
        run_instr(6'b100011, 0, 0, 2, 0, nmw, nrw);
        run_instr(6'b101011, 0, 0, 5, 1, nmw, nrw);
        run_instr(6'b000000, 0, 0, 0, 0, nmw, nrw);

        for (int i = 0; i < 80; i++) begin
            int k = $urandom_range(0, 8);
            rop = (k == 8) ? 6'($urandom) : ops[k];
            run_instr(rop, 1, 0, 0, 0, nmw, nrw);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
